// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed 4-digit hex display scanner with
// frame-synchronous value loading and optional leading-zero blanking.
//
// Ports:
//   clk        system clock, all registers update on its rising edge
//   rst        asynchronous active-high reset
//   value      four hex digits to display, digit k = value[4k+3:4k]
//   load       single-cycle request to capture value
//   blank_lz   enables leading-zero blanking, sampled every cycle
//   nibble     hex code of the active digit (to the segment decoder)
//   an         active-low digit enables, an[k]=0 lights digit k
//   load_ack   one-cycle pulse when a captured value becomes displayed
//   frame_done one-cycle pulse after the digit-3 slot ends
module seven_segment_scanner #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        load_ack,
    output logic        frame_done
);
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
        $error("CLK_DIV out of range 2..65535");
    end

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] div_cnt;
    logic [15:0] disp;
    logic [15:0] pend;
    logic        pend_valid;
    logic [1:0]  idx;
    logic        tick;
    logic        wrap;
    logic        blank;
    logic [15:0] upper;
    logic [3:0]  nibble_d;
    logic [3:0]  an_d;

    // upper holds digits idx..3 in its low bits, so its low nibble is the
    // active digit and a zero value means every digit from idx up is zero.
    always_comb begin
        tick     = div_cnt == LAST;
        wrap     = tick && idx == 2'd3;
        upper    = disp >> {idx, 2'b00};
        blank    = blank_lz && idx != 2'd0 && upper == 16'h0000;
        nibble_d = blank ? 4'h0 : upper[3:0];
        an_d     = blank ? 4'b1111 : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            nibble     <= 4'h0;
            an         <= 4'b1110;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= tick ? 16'h0000 : div_cnt + 16'd1;
            idx        <= tick ? idx + 2'd1 : idx;
            nibble     <= nibble_d;
            an         <= an_d;
            frame_done <= wrap;
            load_ack   <= wrap && (load || pend_valid);
            // A load coinciding with the frame wrap goes straight to disp.
            if (wrap) begin
                disp       <= load ? value : (pend_valid ? pend : disp);
                pend_valid <= 1'b0;
            end else if (load) begin
                pend       <= value;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: randomized and directed checks of the scanner
// against a cycle-count based reference model of the display behaviour.
module tb_seven_segment_scanner;
    localparam int D = 4;
    localparam int FRAME = 4 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble, an, nibble2, an2;
    logic        load_ack, frame_done, load_ack2, frame_done2;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    logic [15:0] m_disp = 16'h0, m_pend = 16'h0;
    logic        m_pv = 1'b0;
    logic [3:0]  exp_nib = 4'h0, exp_an = 4'b1110;
    logic        exp_ack = 1'b0, exp_fd = 1'b0;

    seven_segment_scanner #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .nibble(nibble), .an(an), .load_ack(load_ack), .frame_done(frame_done)
    );

    seven_segment_scanner #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .nibble(nibble2), .an(an2), .load_ack(load_ack2), .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    function automatic string obs();
        return $sformatf("nib=%h an=%b ack=%b fd=%b", nibble, an, load_ack, frame_done);
    endfunction

    function automatic string expd();
        return $sformatf("nib=%h an=%b ack=%b fd=%b", exp_nib, exp_an, exp_ack, exp_fd);
    endfunction

    // Reference model: the displayed slot and frame boundaries follow from
    // the number of cycles since reset release.
    task automatic step();
        int k;
        logic wrap, blanked;
        logic [15:0] up;
        @(posedge clk);
        if (rst) begin
            cyc = 0; m_disp = 0; m_pend = 0; m_pv = 0;
            exp_nib = 4'h0; exp_an = 4'b1110; exp_ack = 0; exp_fd = 0;
        end else begin
            k = (cyc / D) % 4;
            wrap = (cyc % FRAME) == FRAME - 1;
            up = m_disp >> (4 * k);
            blanked = blank_lz && k > 0 && up == 16'h0;
            exp_nib = blanked ? 4'h0 : up[3:0];
            exp_an = blanked ? 4'b1111 : 4'(~(1 << k));
            exp_fd = wrap;
            exp_ack = wrap && (m_pv || load);
            if (wrap) begin
                if (load) m_disp = value;
                else if (m_pv) m_disp = m_pend;
                m_pv = 0;
            end else if (load) begin
                m_pend = value;
                m_pv = 1;
            end
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {4'h0, 4'b1110, 2'b00}) begin
                errors++;
                $display("FAIL reset got %s exp nib=0 an=1110 ack=0 fd=0", obs());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int fd_n = 0, ack_n = 0;
        blank_lz = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            fd_n += int'(frame_done);
            ack_n += int'(load_ack);
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                errors++;
                $display("FAIL idle cyc=%0d got %s exp %s", cyc, obs(), expd());
            end
        end
        checks++;
        if (fd_n !== 2 || ack_n !== 0) begin
            errors++;
            $display("FAIL idle_pulses got fd=%0d ack=%0d exp fd=2 ack=0", fd_n, ack_n);
        end
    endtask

    task automatic test_load_mid();
        int ack_n = 0;
        for (int i = 0; i < FRAME && (cyc / D) % 4 != 1; i++) step();
        value = 16'h1A2F;
        load = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            load = 1'b0;
            ack_n += int'(load_ack);
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                errors++;
                $display("FAIL load_mid cyc=%0d got %s exp %s", cyc, obs(), expd());
            end
        end
        checks++;
        if (ack_n !== 1) begin
            errors++;
            $display("FAIL load_mid_ack got %0d exp 1", ack_n);
        end
    endtask

    task automatic test_blank();
        logic [15:0] vals [2] = '{16'h0030, 16'h0000};
        blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            value = vals[v];
            load = 1'b1;
            for (int i = 0; i < 2 * FRAME + 2; i++) begin
                step();
                load = 1'b0;
                checks++;
                if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                    errors++;
                    $display("FAIL blank v=%h cyc=%0d got %s exp %s", vals[v], cyc, obs(), expd());
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ack_n = 0;
        for (int i = 0; i < FRAME && cyc % FRAME != 2; i++) step();
        for (int i = 0; i < 3 * FRAME; i++) begin
            load = (i == 0 || i == 2);
            value = (i == 0) ? 16'h1111 : 16'h2222;
            step();
            ack_n += int'(load_ack);
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got %s exp %s", cyc, obs(), expd());
            end
        end
        load = 1'b0;
        checks++;
        if (ack_n !== 1) begin
            errors++;
            $display("FAIL back_to_back_ack got %0d exp 1", ack_n);
        end
    endtask

    task automatic test_wrap_load();
        int ack_n = 0;
        for (int i = 0; i < FRAME && cyc % FRAME != FRAME - 1; i++) step();
        value = 16'hBEEF;
        load = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            load = 1'b0;
            ack_n += int'(load_ack);
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                errors++;
                $display("FAIL wrap_load cyc=%0d got %s exp %s", cyc, obs(), expd());
            end
        end
        checks++;
        if (ack_n !== 1 || dut.pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load_ack got ack=%0d pv=%b exp ack=1 pv=0", ack_n, dut.pend_valid);
        end
    endtask

    task automatic test_reset_discard();
        int ack_n = 0;
        for (int i = 0; i < FRAME && cyc % FRAME != 3; i++) step();
        value = 16'h5555;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({nibble, an, load_ack, frame_done} !== {4'h0, 4'b1110, 2'b00}) begin
            errors++;
            $display("FAIL async_reset got %s exp nib=0 an=1110 ack=0 fd=0", obs());
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            ack_n += int'(load_ack);
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                errors++;
                $display("FAIL reset_discard cyc=%0d got %s exp %s", cyc, obs(), expd());
            end
        end
        checks++;
        if (ack_n !== 0 || dut.disp !== 16'h0000) begin
            errors++;
            $display("FAIL reset_discard_state got ack=%0d disp=%h exp ack=0 disp=0000", ack_n, dut.disp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom % 7) == 0;
            value = 16'($urandom);
            if ($urandom % 4 == 0) value = value & 16'h00FF;
            if ($urandom % 4 == 0) value = value & 16'h000F;
            if ($urandom % 23 == 0) blank_lz = ~blank_lz;
            step();
            checks++;
            if ({nibble, an, load_ack, frame_done} !== {exp_nib, exp_an, exp_ack, exp_fd}) begin
                errors++;
                $display("FAIL random cyc=%0d got %s exp %s", cyc, obs(), expd());
            end
        end
        load = 1'b0;
        blank_lz = 1'b0;
    endtask

    task automatic test_clkdiv2();
        logic [3:0] e;
        blank_lz = 1'b0;
        load = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            e = 4'(~(1 << ((i / 2) % 4)));
            checks++;
            if (an2 !== e || nibble2 !== 4'h0) begin
                errors++;
                $display("FAIL clkdiv2 i=%0d got an=%b nib=%h exp an=%b nib=0", i, an2, nibble2, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_mid();
        test_blank();
        test_back_to_back();
        test_wrap_load();
        test_reset_discard();
        test_random();
        test_clkdiv2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
